// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - instruction decode, 4-entry register file and ALU issue stage with forwarding
module decode_issue #(
    parameter int               DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InstrValid,
    input  logic [DATA_W-1:0] InstrByte,
    output logic              InstrReady,
    output logic [DATA_W-1:0] InReg1,
    output logic [DATA_W-1:0] InReg2,
    output logic [2:0]        CtrlSig,
    output logic              Flag,
    output logic              IssueValid,
    input  logic [DATA_W-1:0] AluResult,
    output logic              IllegalOp,
    output logic              Halted,
    input  logic [1:0]        DbgIdx,
    output logic [DATA_W-1:0] DbgData
);

    typedef enum logic [1:0] {
        ST_DECODE = 2'd0,
        ST_IMM    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] in_reg1_q, in_reg2_q;
    logic [2:0]        ctrl_q;
    logic              flag_q;
    logic              issue_valid_q;
    logic              illegal_q;
    logic              halted_q;
    logic [1:0]        wb_rd_q;
    logic [1:0]        ldi_rd_q;

    logic              accept;
    logic [2:0]        op;
    logic [1:0]        rd, rs;
    logic              is_alu, is_ldi, is_halt;
    logic [DATA_W-1:0] src_a_d, src_b_d;

    assign InstrReady = (state_q != ST_HALTED);
    assign accept     = InstrValid && InstrReady;

    assign op      = InstrByte[7:5];
    assign rd      = InstrByte[3:2];
    assign rs      = InstrByte[1:0];
    assign is_alu  = (op == 3'b000) || (op == 3'b011) || (op == 3'b100);
    assign is_ldi  = (op == 3'b001);
    assign is_halt = (op == 3'b111);

    // Operands bypass the register file when the in-flight result targets them.
    always_comb begin
        src_a_d = rf_q[rd];
        src_b_d = rf_q[rs];
        if (issue_valid_q && (rd == wb_rd_q)) src_a_d = AluResult;
        if (issue_valid_q && (rs == wb_rd_q)) src_b_d = AluResult;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= ST_DECODE;
            for (int i = 0; i < 4; i++) rf_q[i] <= RST_VAL;
            in_reg1_q     <= '0;
            in_reg2_q     <= '0;
            ctrl_q        <= '0;
            flag_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            halted_q      <= 1'b0;
            wb_rd_q       <= '0;
            ldi_rd_q      <= '0;
        end else begin
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;

            if (issue_valid_q) rf_q[wb_rd_q] <= AluResult;

            case (state_q)
                ST_DECODE: begin
                    if (accept) begin
                        if (is_alu) begin
                            issue_valid_q <= 1'b1;
                            in_reg1_q     <= src_a_d;
                            in_reg2_q     <= src_b_d;
                            ctrl_q        <= op;
                            flag_q        <= InstrByte[4];
                            wb_rd_q       <= rd;
                        end else if (is_ldi) begin
                            ldi_rd_q <= rd;
                            state_q  <= ST_IMM;
                        end else if (is_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALTED;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_IMM: begin
                    // Placed after the writeback so the immediate wins on a shared index.
                    if (accept) begin
                        rf_q[ldi_rd_q] <= InstrByte;
                        state_q        <= ST_DECODE;
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

    assign InReg1     = in_reg1_q;
    assign InReg2     = in_reg2_q;
    assign CtrlSig    = ctrl_q;
    assign Flag       = flag_q;
    assign IssueValid = issue_valid_q;
    assign IllegalOp  = illegal_q;
    assign Halted     = halted_q;
    assign DbgData    = rf_q[DbgIdx];

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed scoreboard bench for decode_issue
module tb_decode_issue;

    logic       Clk;
    logic       Rst;
    logic       InstrValid;
    logic [7:0] InstrByte;
    logic       InstrReady;
    logic [7:0] InReg1, InReg2;
    logic [2:0] CtrlSig;
    logic       Flag;
    logic       IssueValid;
    logic [7:0] AluResult;
    logic       IllegalOp;
    logic       Halted;
    logic [1:0] DbgIdx;
    logic [7:0] DbgData;

    decode_issue dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InstrValid (InstrValid),
        .InstrByte  (InstrByte),
        .InstrReady (InstrReady),
        .InReg1     (InReg1),
        .InReg2     (InReg2),
        .CtrlSig    (CtrlSig),
        .Flag       (Flag),
        .IssueValid (IssueValid),
        .AluResult  (AluResult),
        .IllegalOp  (IllegalOp),
        .Halted     (Halted),
        .DbgIdx     (DbgIdx),
        .DbgData    (DbgData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] ctrl;
        logic       flag;
        logic [7:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                        input logic f, input logic [7:0] res);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = c; e.flag = f; e.res = res;
        exp_q.push_back(e);
    endtask

    // One clock: drive a byte, then compare any issue against the scoreboard head.
    task automatic cycle(input logic v, input logic [7:0] b);
        exp_t e;
        InstrValid = v;
        InstrByte  = b;
        @(posedge Clk);
        #1;
        InstrValid = 1'b0;
        if (IssueValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("issue_unexpected", 32'(IssueValid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("issue_inreg1", 32'(InReg1), 32'(e.a));
                chk("issue_inreg2", 32'(InReg2), 32'(e.b));
                chk("issue_ctrl", 32'(CtrlSig), 32'(e.ctrl));
                chk("issue_flag", 32'(Flag), 32'(e.flag));
                AluResult = e.res;
            end
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] expv);
        DbgIdx = idx;
        #1;
        chk(tag, 32'(DbgData), 32'(expv));
    endtask

    initial begin
        Rst        = 1'b1;
        InstrValid = 1'b0;
        InstrByte  = 8'h00;
        AluResult  = 8'h00;
        DbgIdx     = 2'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_issue_valid", 32'(IssueValid), 32'd0);
        chk("rst_illegal", 32'(IllegalOp), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_inreg1", 32'(InReg1), 32'd0);
        chk("rst_inreg2", 32'(InReg2), 32'd0);
        chk("rst_ctrl", 32'({CtrlSig, Flag}), 32'd0);
        chk("rst_ready", 32'(InstrReady), 32'd1);
        Rst = 1'b0;

        // LDI R1,5 ; LDI R2,3
        cycle(1'b1, 8'h24);
        cycle(1'b1, 8'h05);
        cycle(1'b1, 8'h28);
        cycle(1'b1, 8'h03);
        chk("ldi_no_issue", 32'(IssueValid), 32'd0);
        chk_reg("ldi_r1", 2'd1, 8'h05);
        chk_reg("ldi_r2", 2'd2, 8'h03);

        // ADD R1,R2 and writeback
        push(8'h05, 8'h03, 3'b011, 1'b1, 8'h08);
        cycle(1'b1, 8'h76);
        chk("add_issue_valid", 32'(IssueValid), 32'd1);
        chk_reg("add_dbg_prewrite", 2'd1, 8'h05);
        cycle(1'b0, 8'h00);
        chk("add_issue_drop", 32'(IssueValid), 32'd0);
        chk_reg("add_wb_r1", 2'd1, 8'h08);

        // Back-to-back with forwarding on rs
        push(8'h08, 8'h03, 3'b011, 1'b1, 8'h08);
        cycle(1'b1, 8'h76);
        push(8'h03, 8'h08, 3'b011, 1'b0, 8'hFB);
        cycle(1'b1, 8'h69);
        chk("b2b_issue_valid", 32'(IssueValid), 32'd1);
        cycle(1'b0, 8'h00);
        chk_reg("b2b_r2", 2'd2, 8'hFB);
        chk_reg("b2b_r1", 2'd1, 8'h08);

        // Both operands forwarded at once
        push(8'hFB, 8'hFB, 3'b011, 1'b1, 8'h10);
        cycle(1'b1, 8'h7A);
        push(8'h10, 8'h10, 3'b100, 1'b1, 8'h20);
        cycle(1'b1, 8'h9A);
        cycle(1'b0, 8'h00);
        chk_reg("fwd2_r2", 2'd2, 8'h20);

        // Illegal opcode
        cycle(1'b1, 8'h40);
        chk("illegal_pulse", 32'(IllegalOp), 32'd1);
        chk("illegal_no_issue", 32'(IssueValid), 32'd0);
        chk_reg("illegal_r1", 2'd1, 8'h08);
        chk_reg("illegal_r2", 2'd2, 8'h20);
        push(8'h08, 8'h20, 3'b011, 1'b1, 8'h00);
        cycle(1'b1, 8'h76);
        chk("illegal_one_cycle", 32'(IllegalOp), 32'd0);
        cycle(1'b0, 8'h00);
        chk_reg("after_illegal_r1", 2'd1, 8'h00);

        // HALT
        cycle(1'b1, 8'hE0);
        chk("halt_halted", 32'(Halted), 32'd1);
        chk("halt_ready", 32'(InstrReady), 32'd0);
        cycle(1'b1, 8'h76);
        cycle(1'b1, 8'h76);
        chk("halt_no_issue", 32'(IssueValid), 32'd0);
        chk("halt_stays", 32'(Halted), 32'd1);
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        #1;
        chk("unhalt_halted", 32'(Halted), 32'd0);
        chk("unhalt_ready", 32'(InstrReady), 32'd1);
        for (int i = 0; i < 4; i++) chk_reg("unhalt_reg", 2'(i), 8'h00);

        // Reset in the middle of an LDI discards it
        @(posedge Clk);
        #1;
        cycle(1'b1, 8'h24);
        #2;
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        push(8'h00, 8'h00, 3'b000, 1'b0, 8'h55);
        cycle(1'b1, 8'h05);
        chk("midldi_issue_valid", 32'(IssueValid), 32'd1);
        cycle(1'b0, 8'h00);
        chk_reg("midldi_r1", 2'd1, 8'h55);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
